// File: rtl/fetch_unit.sv
// fetch_unit: rv32i fetch stage; PC, ROM address, and {pc, instr} FIFO to decode.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect sets misalign and halts until rst.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   pc_mem_q [FIFO_DEPTH];
    logic [31:0]   pc_mem_d [FIFO_DEPTH];
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   instr_mem_d [FIFO_DEPTH];
    logic          run, pop, push;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;
    logic [0:0] state_q, state_d;
    logic       misalign_q, misalign_d;
    assign run      = (state_q == RUN);
    assign misalign = misalign_q;
`else
    assign run      = 1'b1;
    assign misalign = 1'b0;
`endif

    always_comb begin
        pop         = (count_q != '0) && out_ready;
        push        = run && !redirect_valid && ((count_q < FULL) || pop);
        fetch_pc_d  = fetch_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        state_d     = state_q;
        misalign_d  = misalign_q;
`endif
        if (run && redirect_valid) begin
            // Flush drops every buffered entry, including one popped this cycle
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                misalign_d = 1'b1;
            end else begin
                fetch_pc_d = redirect_pc;
            end
`else
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = imem_data;
                wr_ptr_d              = wr_ptr_q + AW'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (pop && !push) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pc_mem_q    <= '{default: '0};
            instr_mem_q <= '{default: '0};
`ifdef FETCH_MISALIGN_TRAP_EN
            state_q     <= RUN;
            misalign_q  <= 1'b0;
`endif
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            state_q     <= state_d;
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus for fetch_unit against a
// queue-based reference model of the fetch/flush/handshake rules.
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_data;
    logic        rv;
    logic [31:0] rpc;
    logic        out_valid, ready;
    logic [31:0] out_instr, out_pc;
    logic        misalign;

    logic [31:0] imem_addr_w, imem_data_w, oi_w, opc_w;
    logic        ov_w, mis_w;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q[$];
    logic [31:0] mpc;
    bit          halted;
    bit          mmis;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'd0) return 32'd0;
        if (a == 32'd4) return 32'h02A0_0093;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_data   = rom(imem_addr);
    assign imem_data_w = rom(imem_addr_w);

    fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(rv), .redirect_pc(rpc),
        .out_valid(out_valid), .out_ready(ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .misalign(misalign)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr_w), .imem_data(imem_data_w),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(ov_w), .out_ready(1'b1),
        .out_instr(oi_w), .out_pc(opc_w),
        .misalign(mis_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        q.delete();
        mpc    = 32'h0;
        halted = 0;
        mmis   = 0;
    endtask

    task automatic check_all();
        chk("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
        end
        chk("imem_addr", imem_addr, mpc);
        chk("misalign", {31'd0, misalign}, {31'd0, mmis});
    endtask

    task automatic model_edge();
        bit p;
        if (halted) return;
        p = (q.size() != 0) && ready;
        if (rv) begin
            q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            if (rpc % 4 != 0) begin
                halted = 1;
                mmis   = 1;
                return;
            end
`endif
            mpc = rpc - (rpc % 4);
        end else if (q.size() < DEPTH || p) begin
            if (p) void'(q.pop_front());
            q.push_back('{mpc, rom(mpc)});
            mpc = mpc + 32'd4;
        end
    endtask

    task automatic step();
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mreset();
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_addr_w", imem_addr_w, WRAP_PC);
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b1;
        rv    = 1'b0;
        rpc   = 32'h0;
        do_reset();

        // Stream from reset, plus the wrapping instance
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc", out_pc, 32'(4 * k));
            chk("wrap_valid", {31'd0, ov_w}, 32'd1);
            chk("wrap_pc", opc_w, WRAP_PC + 32'(4 * k));
        end
        chk("second_instr_src", rom(32'd4), 32'h02A0_0093);

        // Backpressure from an empty FIFO at pc 0
        rv = 1'b1; rpc = 32'h0;
        step();
        rv = 1'b0; ready = 1'b0;
        repeat (5) step();
        chk("bp_hold_pc", out_pc, 32'd0);
        chk("bp_addr", imem_addr, 32'd8);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_order", out_pc, 32'(4 * k));
            step();
        end

        // Redirect with a full FIFO holding pcs 0 and 4
        rv = 1'b1; rpc = 32'h0;
        step();
        rv = 1'b0; ready = 1'b0;
        repeat (2) step();
        ready = 1'b1; rv = 1'b1; rpc = 32'h14;
        chk("rd_head", out_pc, 32'd0);
        step();
        rv = 1'b0;
        chk("rd_bubble", {31'd0, out_valid}, 32'd0);
        step();
        chk("rd_tgt", out_pc, 32'h14);
        step();
        chk("rd_next", out_pc, 32'h18);

        // Misaligned redirect target
        rv = 1'b1; rpc = 32'h16;
        step();
        rv = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_set", {31'd0, misalign}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            rv = 1'b1; rpc = 32'(k * 8);
            step();
            chk("halt_valid", {31'd0, out_valid}, 32'd0);
        end
        rv = 1'b0;
        do_reset();
        chk("mis_clr", {31'd0, misalign}, 32'd0);
`else
        chk("mis_bubble", {31'd0, out_valid}, 32'd0);
        step();
        chk("mis_tgt", out_pc, 32'h14);
        chk("mis_zero", {31'd0, misalign}, 32'd0);
`endif

        // Random traffic
        repeat (400) begin
            ready = ($urandom % 4) != 0;
            rv    = ($urandom % 8) == 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc   = 32'($urandom_range(0, 255)) << 2;
`else
            rpc   = 32'($urandom_range(0, 1023));
`endif
            step();
        end
        rv = 1'b0;

        // Asynchronous reset with a full FIFO
        ready = 1'b0;
        repeat (3) step();
        chk("pre_async_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {31'd0, out_valid}, 32'd0);
        chk("async_mis", {31'd0, misalign}, 32'd0);
        chk("async_addr", imem_addr, 32'd0);
        mreset();
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the rv32i core. Holds the program counter, drives the instruction ROM address, captures the returned word and buffers `{pc, instr}` pairs in a small FIFO. Decode consumes the pairs through a valid/ready handshake. Execute can redirect fetch on a taken branch or jump, which flushes all buffered fetches.

## Interface

Parameters:
- `RESET_PC`, default `32'h0000_0000`: fetch address after reset; must be word-aligned.
- `FIFO_DEPTH`, default `2`: buffer entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `imem_addr`  out  32  — byte address to the ROM; always equals `fetch_pc`.
- `imem_data`  in  32  — ROM word; combinational, valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  — branch/jump taken this cycle.
- `redirect_pc`  in  32  — redirect target byte address.
- `out_valid`  out  1  — FIFO head holds a valid entry.
- `out_ready`  in  1  — decode accepts the head entry.
- `out_instr`  out  32  — instruction word at the FIFO head.
- `out_pc`  out  32  — byte address of `out_instr`.
- `misalign`  out  1  — sticky misaligned-redirect flag.

## Operation

- State: `fetch_pc` (32b), FIFO storage, read/write pointers, occupancy `count` (log2(FIFO_DEPTH)+1 bits), FSM `{RUN, HALT}`.
- Reset values: `fetch_pc = RESET_PC`, FIFO empty, FSM = RUN, `out_valid = 0`, `misalign = 0`, `out_pc = 0`, `out_instr = 0`.
- pop = `out_valid && out_ready`.
- push = RUN && !`redirect_valid` && (`count < FIFO_DEPTH` || pop).
  - When full, a push and a pop in the same cycle are both performed.
- On push:
  - Write `{fetch_pc, imem_data}` at the write pointer.
  - `fetch_pc <= fetch_pc + 4`, modulo 2^32, so `32'hFFFF_FFFC` wraps to `0`.
- On redirect (RUN):
  - Clear the FIFO, including any entry being popped; a pop in that cycle still completes.
  - `fetch_pc <= redirect_pc`; no push that cycle.
  - Redirect has priority over push.
- `out_valid = (count != 0)`.
- `out_pc`/`out_instr` show the head entry; they are don't-care when `out_valid = 0`, but must not be X after reset.
- Entries are delivered to decode in fetch order, each exactly once.
- HALT (only reachable with the macro):
  - No push, FIFO empty, `out_valid = 0`, `fetch_pc` frozen.
  - Redirects are ignored.
  - Exit only by `rst`.
- `rst` asserted mid-operation returns all state to reset values immediately, independent of `clk`.

## Timing

- Fetch latency: 1 cycle. An instruction fetched in cycle n is presented on `out_*` in cycle n+1.
- After reset deassertion:
  - The first rising edge pushes `RESET_PC`.
  - `out_valid = 1` from that edge onward.
- Throughput: 1 instruction/cycle while `out_ready = 1`.
- Redirect asserted in cycle n:
  - `out_valid = 0` in cycle n+1 (one bubble).
  - The target is presented in cycle n+2.
- Backpressure:
  - With `out_ready = 0`, the FIFO fills in `FIFO_DEPTH` cycles.
  - `imem_addr` then holds until a pop occurs.
- `misalign` is registered: it rises on the edge ending the offending redirect cycle.

## Configuration

- Macro `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect in RUN with `redirect_pc[1:0] != 0` flushes the FIFO.
  - It sets `misalign = 1` and enters HALT; `fetch_pc` is not updated.
- Undefined:
  - `redirect_pc[1:0]` is ignored and treated as `2'b00`.
  - `misalign` is tied to 0; HALT logic is not built.

## Test plan

- Reset release with ROM word 0 = `0`, word 1 = `0x02A00093`, `out_ready = 1` → outputs in order `(pc 0, instr 0)`, then `(4, 0x02A00093)`, then `(8, word 2)`, one per cycle.
- `out_ready = 0` for 5 cycles after the first valid → `out_pc` stays 0, `imem_addr` holds at 8 (DEPTH 2). After release, pcs 0, 4, 8, 12 arrive in order with no gap, loss or duplicate.
- FIFO full (pcs 0, 4), redirect to `0x14` with `out_ready = 1` → pc 0 popped that cycle, next cycle `out_valid = 0`, then `out_pc = 0x14`, `0x18`; pc 4 never presented.
- `RESET_PC = 32'hFFFF_FFF8`, `out_ready = 1` → `out_pc` sequence `FFFF_FFF8`, `FFFF_FFFC`, `0000_0000`.
- Redirect to `0x16`:
  - With macro: `misalign = 1` next cycle; `out_valid = 0` for the following 10 cycles despite further redirects; `rst` clears it.
  - Without macro: `out_pc = 0x14` two cycles later; `misalign = 0`.
- Assert `rst` asynchronously mid-stream with the FIFO full → `out_valid`, `count` and `misalign` go to 0 before the next edge; `imem_addr = RESET_PC`.
